autoconfig_master: RTL and testbench

- Host-side Zorro II Autoconfig initiator; the opposite end of the card-side responder protocol.
- On `start`, acts as a 68000-style bus master and walks the config chain at $E8xxxx.
- For each board it reads the ID nibbles, allocates a size-aligned base in the 64K-unit window [BASE_START..BASE_END], and writes that base back, or tells the board to shut up.
- Used in the CPLD test harness and by any slot-controller design that must configure downstream cards.

---
 rtl/autoconfig_master.sv | 294 +++++++++++++++++++++++++++++
 tb/tb_autoconfig_master.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/autoconfig_master.sv
// Zorro II Autoconfig initiator: walks the $E8xxxx config chain, reads each board's ID,
// allocates a size-aligned base in the 64K window and writes it back (or shuts the board up).
module autoconfig_master #(
  parameter logic [7:0] BASE_START     = 8'hE9,
  parameter logic [7:0] BASE_END       = 8'hEF,
  parameter int         MAX_BOARDS     = 8,
  parameter int         TIMEOUT_CYCLES = 16
) (
  input  logic        CLK,
  input  logic        RESET_n,
  input  logic        start,
  output logic [23:1] ADDR,
  output logic        AS_n,
  output logic        UDS_n,
  output logic        RW,
  output logic [3:0]  DOUT,
  output logic        DOE,
  input  logic [3:0]  DIN,
  input  logic        DTACK_n,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [3:0]  board_count,
  output logic [15:0] last_mfg,
  output logic [7:0]  last_prod,
  output logic [7:0]  last_base
);

  localparam int             WCW       = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]     MAX_B     = 4'(MAX_BOARDS);

  // Steps 0..7 are the ID reads; 8..10 are the possible configuration writes.
  localparam logic [3:0] STEP_LAST_READ = 4'd7;
  localparam logic [3:0] STEP_WR_LO     = 4'd8;
  localparam logic [3:0] STEP_WR_HI     = 4'd9;
  localparam logic [3:0] STEP_SHUTUP    = 4'd10;

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STROBE, S_TERM, S_RECOVER} state_t;

  state_t          state_reg, state_next;
  logic [3:0]      step_reg, step_next;
  logic [WCW-1:0]  wait_reg, wait_next;
  logic            timeout_reg, timeout_next;
  logic [3:0]      loop_reg, loop_next;
  logic [8:0]      next_base_reg, next_base_next;
  logic [1:0]      type_hi_reg, type_hi_next;
  logic [2:0]      size_code_reg, size_code_next;
  logic [7:0]      prod_reg, prod_next;
  logic [15:0]     mfg_reg, mfg_next;
  logic [23:1]     addr_reg, addr_next;
  logic            as_n_reg, as_n_next;
  logic            uds_n_reg, uds_n_next;
  logic            rw_reg, rw_next;
  logic [3:0]      dout_reg, dout_next;
  logic            doe_reg, doe_next;
  logic            busy_reg, busy_next;
  logic            done_reg, done_next;
  logic            err_reg, err_next;
  logic [3:0]      board_count_reg, board_count_next;
  logic [15:0]     last_mfg_reg, last_mfg_next;
  logic [7:0]      last_prod_reg, last_prod_next;
  logic [7:0]      last_base_reg, last_base_next;

  logic [8:0] units, aligned;
  logic       valid, fit;
  logic       launch, board_end, end_scan;

  function automatic logic [7:0] step_index(input logic [3:0] s);
    case (s)
      4'd0:    return 8'h00;
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h03;
      4'd4:    return 8'h08;
      4'd5:    return 8'h09;
      4'd6:    return 8'h0A;
      4'd7:    return 8'h0B;
      4'd8:    return 8'h25;
      4'd9:    return 8'h24;
      default: return 8'h26;
    endcase
  endfunction

  // Allocation works in 9 bits so rounding past $FF cannot wrap back into the window.
  always_comb begin
    units   = (size_code_reg == 3'd0) ? 9'd128 : (9'd1 << (size_code_reg - 3'd1));
    aligned = (next_base_reg + units - 9'd1) & ~(units - 9'd1);
    fit     = (aligned + units - 9'd1) <= {1'b0, BASE_END};
    valid   = (type_hi_reg == 2'b11);
  end

  always_comb begin
    state_next       = state_reg;
    step_next        = step_reg;
    wait_next        = wait_reg;
    timeout_next     = timeout_reg;
    loop_next        = loop_reg;
    next_base_next   = next_base_reg;
    type_hi_next     = type_hi_reg;
    size_code_next   = size_code_reg;
    prod_next        = prod_reg;
    mfg_next         = mfg_reg;
    addr_next        = addr_reg;
    rw_next          = rw_reg;
    dout_next        = dout_reg;
    busy_next        = busy_reg;
    done_next        = 1'b0;
    err_next         = err_reg;
    board_count_next = board_count_reg;
    last_mfg_next    = last_mfg_reg;
    last_prod_next   = last_prod_reg;
    last_base_next   = last_base_reg;
    launch           = 1'b0;
    board_end        = 1'b0;
    end_scan         = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (start) begin
          busy_next        = 1'b1;
          err_next         = 1'b0;
          board_count_next = 4'd0;
          next_base_next   = {1'b0, BASE_START};
          loop_next        = 4'd0;
          step_next        = 4'd0;
          launch           = 1'b1;
        end
      end
      S_SETUP: begin
        wait_next    = '0;
        timeout_next = 1'b0;
        state_next   = S_STROBE;
      end
      S_STROBE: begin
        if (!DTACK_n) begin
          state_next = S_TERM;
          if (rw_reg) begin
            case (step_reg)
              4'd0:    type_hi_next   = DIN[3:2];
              4'd1:    size_code_next = DIN[2:0];
              4'd2:    prod_next[7:4] = ~DIN;
              4'd3:    prod_next[3:0] = ~DIN;
              4'd4:    mfg_next[15:12] = ~DIN;
              4'd5:    mfg_next[11:8]  = ~DIN;
              4'd6:    mfg_next[7:4]   = ~DIN;
              4'd7:    mfg_next[3:0]   = ~DIN;
              default: ;
            endcase
          end
        end else if (wait_reg == WAIT_LAST) begin
          timeout_next = 1'b1;
          state_next   = S_TERM;
        end else begin
          wait_next = wait_reg + WCW'(1);
        end
      end
      S_TERM: state_next = S_RECOVER;
      S_RECOVER: begin
        if (timeout_reg) begin
          // Silence on the first ID read just means the chain is exhausted.
          if (step_reg != 4'd0) err_next = 1'b1;
          end_scan = 1'b1;
        end else begin
          case (step_reg)
            STEP_LAST_READ: begin
              last_mfg_next  = mfg_reg;
              last_prod_next = prod_reg;
              if (valid && fit) begin
                step_next = STEP_WR_LO;
              end else begin
                step_next = STEP_SHUTUP;
                err_next  = 1'b1;
              end
              launch = 1'b1;
            end
            STEP_WR_LO: begin
              step_next = STEP_WR_HI;
              launch    = 1'b1;
            end
            STEP_WR_HI: begin
              last_base_next   = aligned[7:0];
              next_base_next   = aligned + units;
              board_count_next = board_count_reg + 4'd1;
              board_end        = 1'b1;
            end
            STEP_SHUTUP: board_end = 1'b1;
            default: begin
              step_next = step_reg + 4'd1;
              launch    = 1'b1;
            end
          endcase
        end
      end
      default: state_next = S_IDLE;
    endcase

    if (board_end) begin
      loop_next = loop_reg + 4'd1;
      if (board_count_next == MAX_B || loop_next == MAX_B) begin
        end_scan = 1'b1;
      end else begin
        step_next = 4'd0;
        launch    = 1'b1;
      end
    end

    if (end_scan) begin
      state_next = S_IDLE;
      busy_next  = 1'b0;
      done_next  = 1'b1;
    end

    if (launch) begin
      state_next = S_SETUP;
      addr_next  = {8'hE8, 7'd0, step_index(step_next)};
      rw_next    = (step_next < STEP_WR_LO);
      if (step_next == STEP_WR_LO)      dout_next = aligned[3:0];
      else if (step_next == STEP_WR_HI) dout_next = aligned[7:4];
      else                              dout_next = 4'd0;
    end

    as_n_next  = (state_next != S_STROBE);
    uds_n_next = (state_next != S_STROBE);
    doe_next   = (state_next == S_STROBE) && !rw_next;
  end

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state_reg       <= S_IDLE;
      step_reg        <= 4'd0;
      wait_reg        <= '0;
      timeout_reg     <= 1'b0;
      loop_reg        <= 4'd0;
      next_base_reg   <= {1'b0, BASE_START};
      type_hi_reg     <= 2'd0;
      size_code_reg   <= 3'd0;
      prod_reg        <= 8'd0;
      mfg_reg         <= 16'd0;
      addr_reg        <= '0;
      as_n_reg        <= 1'b1;
      uds_n_reg       <= 1'b1;
      rw_reg          <= 1'b1;
      dout_reg        <= 4'd0;
      doe_reg         <= 1'b0;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
      err_reg         <= 1'b0;
      board_count_reg <= 4'd0;
      last_mfg_reg    <= 16'd0;
      last_prod_reg   <= 8'd0;
      last_base_reg   <= 8'd0;
    end else begin
      state_reg       <= state_next;
      step_reg        <= step_next;
      wait_reg        <= wait_next;
      timeout_reg     <= timeout_next;
      loop_reg        <= loop_next;
      next_base_reg   <= next_base_next;
      type_hi_reg     <= type_hi_next;
      size_code_reg   <= size_code_next;
      prod_reg        <= prod_next;
      mfg_reg         <= mfg_next;
      addr_reg        <= addr_next;
      as_n_reg        <= as_n_next;
      uds_n_reg       <= uds_n_next;
      rw_reg          <= rw_next;
      dout_reg        <= dout_next;
      doe_reg         <= doe_next;
      busy_reg        <= busy_next;
      done_reg        <= done_next;
      err_reg         <= err_next;
      board_count_reg <= board_count_next;
      last_mfg_reg    <= last_mfg_next;
      last_prod_reg   <= last_prod_next;
      last_base_reg   <= last_base_next;
    end
  end

  assign ADDR        = addr_reg;
  assign AS_n        = as_n_reg;
  assign UDS_n       = uds_n_reg;
  assign RW          = rw_reg;
  assign DOUT        = dout_reg;
  assign DOE         = doe_reg;
  assign busy        = busy_reg;
  assign done        = done_reg;
  assign err         = err_reg;
  assign board_count = board_count_reg;
  assign last_mfg    = last_mfg_reg;
  assign last_prod   = last_prod_reg;
  assign last_base   = last_base_reg;

endmodule

// File: tb/tb_autoconfig_master.sv
// Bench for autoconfig_master: a chain of model cards answers bus cycles; expected cycles and
// scan results come from a behavioural allocator and are checked by two independent monitors.
module tb_autoconfig_master;

  logic        CLK = 1'b0;
  logic        RESET_n = 1'b0;
  logic        start = 1'b0;
  logic [23:1] ADDR;
  logic        AS_n, UDS_n, RW, DOE;
  logic [3:0]  DOUT;
  logic [3:0]  DIN = 4'd0;
  logic        DTACK_n = 1'b1;
  logic        busy, done, err;
  logic [3:0]  board_count;
  logic [15:0] last_mfg;
  logic [7:0]  last_prod, last_base;

  always #5 CLK = ~CLK;

  autoconfig_master dut (
    .CLK(CLK), .RESET_n(RESET_n), .start(start),
    .ADDR(ADDR), .AS_n(AS_n), .UDS_n(UDS_n), .RW(RW), .DOUT(DOUT), .DOE(DOE),
    .DIN(DIN), .DTACK_n(DTACK_n),
    .busy(busy), .done(done), .err(err), .board_count(board_count),
    .last_mfg(last_mfg), .last_prod(last_prod), .last_base(last_base)
  );

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  // Card chain seen by the bus: cards[cur] is the one currently answering at $E8xxxx.
  logic [3:0]  c_type [16];
  logic [3:0]  c_size [16];
  logic [15:0] c_mfg  [16];
  logic [7:0]  c_prod [16];
  int          c_waits[16];
  logic [7:0]  c_fail [16];
  int          ncards = 0;
  int          cur = 0;
  bit          mon_off = 1'b0;

  logic [7:0] rd_idx [8] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h08, 8'h09, 8'h0A, 8'h0B};

  function automatic logic [3:0] read_nib(input int k, input logic [7:0] i);
    case (i)
      8'h00:   return c_type[k];
      8'h01:   return c_size[k];
      8'h02:   return ~c_prod[k][7:4];
      8'h03:   return ~c_prod[k][3:0];
      8'h08:   return ~c_mfg[k][15:12];
      8'h09:   return ~c_mfg[k][11:8];
      8'h0A:   return ~c_mfg[k][7:4];
      8'h0B:   return ~c_mfg[k][3:0];
      default: return 4'hF;
    endcase
  endfunction

  task automatic add_card(input logic [3:0] t, input logic [3:0] s, input logic [15:0] m,
                          input logic [7:0] p, input int w, input logic [7:0] f);
    c_type[ncards] = t; c_size[ncards] = s; c_mfg[ncards] = m;
    c_prod[ncards] = p; c_waits[ncards] = w; c_fail[ncards] = f;
    ncards++;
  endtask

  initial begin : responder
    int age;
    logic [7:0] ridx;
    logic rrw, racked;
    age = 0; ridx = 8'd0; rrw = 1'b1; racked = 1'b0;
    forever begin
      @(negedge CLK);
      if (!AS_n) begin
        age++;
        if (age == 1) begin ridx = ADDR[8:1]; rrw = RW; end
        if (cur < ncards && ADDR[23:16] == 8'hE8 && ridx != c_fail[cur] && age > c_waits[cur]) begin
          DTACK_n = 1'b0;
          DIN = read_nib(cur, ridx);
          racked = 1'b1;
        end else begin
          DTACK_n = 1'b1;
        end
      end else begin
        // Configuring or shutting up a card passes the chain on to the next one.
        if (age > 0 && racked && !rrw && (ridx == 8'h24 || ridx == 8'h26)) cur++;
        age = 0; racked = 1'b0; DTACK_n = 1'b1;
      end
    end
  end

  typedef struct { logic [7:0] idx; logic rw; logic [3:0] data; int len; } bus_t;
  typedef struct { logic err; logic [3:0] cnt; logic [15:0] mfg; logic [7:0] prod; logic [7:0] base; } res_t;
  bus_t exp_bus[$];
  res_t exp_res[$];
  logic [15:0] m_mfg = 16'd0;
  logic [7:0]  m_prod = 8'd0;
  logic [7:0]  m_base = 8'd0;

  task automatic push_bus(input logic [7:0] i, input logic r, input logic [3:0] d, input int l);
    bus_t b;
    b.idx = i; b.rw = r; b.data = d; b.len = l;
    exp_bus.push_back(b);
  endtask

  // Reference allocator: walks the card list exactly as a host would, in plain arithmetic.
  task automatic build_expect();
    int nb, cnt, loops, c, u, al, code, w;
    logic e;
    bit ended;
    nb = 'hE9; cnt = 0; loops = 0; c = 0; e = 1'b0;
    forever begin
      if (c >= ncards) begin push_bus(8'h00, 1'b1, 4'd0, 16); break; end
      ended = 1'b0;
      w = c_waits[c];
      for (int k = 0; k < 8; k++) begin
        if (c_fail[c] == rd_idx[k]) begin
          push_bus(rd_idx[k], 1'b1, 4'd0, 16);
          if (k != 0) e = 1'b1;
          ended = 1'b1;
          break;
        end
        push_bus(rd_idx[k], 1'b1, 4'd0, w + 1);
      end
      if (ended) break;
      m_mfg = c_mfg[c]; m_prod = c_prod[c];
      code = int'(c_size[c][2:0]);
      u = (code == 0) ? 128 : (1 << (code - 1));
      al = ((nb + u - 1) / u) * u;
      if (c_type[c][3:2] == 2'b11 && al + u - 1 <= 'hEF) begin
        push_bus(8'h25, 1'b0, 4'(al % 16), w + 1);
        push_bus(8'h24, 1'b0, 4'((al / 16) % 16), w + 1);
        m_base = 8'(al); nb = al + u; cnt++;
      end else begin
        push_bus(8'h26, 1'b0, 4'd0, w + 1);
        e = 1'b1;
      end
      c++; loops++;
      if (cnt == 8 || loops == 8) break;
    end
    exp_res.push_back('{e, 4'(cnt), m_mfg, m_prod, m_base});
  endtask

  initial begin : bus_mon
    int len, gap;
    logic [23:1] a;
    logic r, oe, uds;
    logic [3:0] d;
    bit in_s, have_prev;
    bus_t eb;
    len = 0; gap = 0; in_s = 1'b0; have_prev = 1'b0;
    a = '0; r = 1'b1; oe = 1'b0; uds = 1'b1; d = 4'd0;
    forever begin
      @(negedge CLK);
      if (mon_off) begin in_s = 1'b0; have_prev = 1'b0; continue; end
      if (!AS_n) begin
        if (!in_s) begin
          in_s = 1'b1; len = 0;
          a = ADDR; r = RW; d = DOUT; oe = DOE; uds = UDS_n;
          if (have_prev) check("strobe_gap", gap, 3);
        end
        len++;
      end else begin
        if (in_s) begin
          in_s = 1'b0; have_prev = 1'b1; gap = 1;
          if (exp_bus.size() == 0) begin
            check("bus_extra_cycle", a, 0);
          end else begin
            eb = exp_bus.pop_front();
            check("bus_addr", a, {8'hE8, 7'd0, eb.idx});
            check("bus_ctl", {r, oe, uds}, {eb.rw, ~eb.rw, 1'b0});
            if (!eb.rw) check("bus_wdata", d, eb.data);
            check("bus_len", len, eb.len);
          end
        end else if (have_prev) begin
          gap++;
        end
        if (!busy) have_prev = 1'b0;
      end
    end
  end

  initial begin : res_mon
    res_t er;
    forever begin
      @(negedge CLK);
      if (done) begin
        if (exp_res.size() == 0) begin
          check("res_extra_done", done, 0);
        end else begin
          er = exp_res.pop_front();
          $display("scan done: err=%0d count=%0d mfg=%h prod=%h base=%h", err, board_count, last_mfg, last_prod, last_base);
          check("res_err", err, er.err);
          check("res_count", board_count, er.cnt);
          check("res_mfg", last_mfg, er.mfg);
          check("res_prod", last_prod, er.prod);
          check("res_base", last_base, er.base);
          check("res_idle", {busy, AS_n, UDS_n, DOE}, 4'b0110);
          check("res_bus_left", exp_bus.size(), 0);
        end
        @(negedge CLK);
        check("done_width", done, 0);
      end
    end
  end

  task automatic run_scan(input int extra_start_at);
    bit seen;
    cur = 0;
    build_expect();
    @(negedge CLK); start = 1'b1;
    @(negedge CLK); start = 1'b0;
    check("start_busy", busy, 1);
    check("start_err_clear", err, 0);
    check("start_count_clear", board_count, 0);
    seen = 1'b0;
    for (int n = 0; n < 6000 && !seen; n++) begin
      start = (n == extra_start_at);
      @(negedge CLK);
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    if (!seen) begin
      check("scan_timeout", seen, 1);
      exp_bus.delete(); exp_res.delete();
    end
    repeat (3) @(negedge CLK);
  endtask

  initial begin
    logic [3:0] t, s;
    logic [7:0] f;
    bit seen;
    repeat (2) @(negedge CLK);
    check("rst_strobes", {AS_n, UDS_n, RW, DOE}, 4'b1110);
    check("rst_addr_dout", {ADDR, DOUT}, 27'd0);
    check("rst_status", {busy, done, err, board_count}, 7'd0);
    check("rst_last", {last_mfg, last_prod, last_base}, 32'd0);
    RESET_n = 1'b1;
    repeat (2) @(negedge CLK);

    ncards = 0; add_card(4'b1101, 4'b0010, 16'd5194, 8'd6, 0, 8'hFF); run_scan(-1);
    ncards = 0; run_scan(-1);
    ncards = 0; add_card(4'b1101, 4'b0010, 16'h1111, 8'h21, 0, 8'hFF);
    add_card(4'b1100, 4'b0010, 16'h2222, 8'h42, 3, 8'hFF); run_scan(-1);
    ncards = 0; add_card(4'b1101, 4'b0101, 16'h0BAD, 8'h13, 0, 8'hFF); run_scan(-1);
    ncards = 0; add_card(4'b1000, 4'b0010, 16'h0C0D, 8'h77, 1, 8'hFF); run_scan(-1);
    ncards = 0; add_card(4'b1101, 4'b0010, 16'h3456, 8'h99, 0, 8'h09); run_scan(-1);
    ncards = 0; add_card(4'b1101, 4'b0001, 16'h4242, 8'h05, 2, 8'hFF); run_scan(5);
    ncards = 0; add_card(4'b1101, 4'b0010, 16'd5194, 8'd6, 0, 8'hFF); run_scan(-1);
    ncards = 0;
    for (int k = 0; k < 9; k++) add_card(4'b1100, 4'b0001, 16'(k * 257), 8'(k), 0, 8'hFF);
    run_scan(-1);

    for (int r = 0; r < 14; r++) begin
      ncards = $urandom_range(0, 9);
      for (int k = 0; k < ncards; k++) begin
        t = ($urandom_range(0, 7) == 0) ? 4'($urandom) : {2'b11, 2'($urandom)};
        s = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 2)) : 4'($urandom_range(0, 15));
        f = ($urandom_range(0, 11) == 0) ? rd_idx[$urandom_range(0, 7)] : 8'hFF;
        c_type[k] = t; c_size[k] = s; c_mfg[k] = 16'($urandom); c_prod[k] = 8'($urandom);
        c_waits[k] = $urandom_range(0, 4); c_fail[k] = f;
      end
      run_scan(($urandom_range(0, 1) == 1) ? $urandom_range(1, 40) : -1);
    end

    // Reset in the middle of a long strobe must release the bus without a clock edge.
    mon_off = 1'b1;
    ncards = 0; add_card(4'b1101, 4'b0010, 16'h5555, 8'h55, 8, 8'hFF);
    cur = 0;
    @(negedge CLK); start = 1'b1;
    @(negedge CLK); start = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 50 && !seen; n++) begin
      @(negedge CLK);
      if (!AS_n) seen = 1'b1;
    end
    check("reset_test_strobe_seen", seen, 1);
    #2 RESET_n = 1'b0;
    #1 check("reset_mid_strobe", {AS_n, UDS_n, busy, DOE}, 4'b1100);
    @(negedge CLK);
    check("reset_mid_status", {err, board_count, last_base}, 13'd0);
    RESET_n = 1'b1;
    repeat (2) @(negedge CLK);
    check("reset_idle_after", {busy, AS_n}, 2'b01);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
